uart_to_waveform: RTL and testbench
===================================

// Module: uart_to_waveform
// PURPOSE
//  PC-side/loopback receiver for the ADC waveform serial stream. Deserialises the 8N1 byte stream
//  (start 0, 8 data LSB-first, stop 1) and reassembles 3-byte records {hi[5:0], lo[7:0], index}
//  into 14-bit samples. Stores the samples in a 32-entry waveform buffer and flags a complete
//  waveform. Used for board-level loopback checking and bridging into a host capture path.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit period; must be >=4 and even
//  N_SAMPLES     32  samples per waveform; the index byte ranges 0..N_SAMPLES-1
//  IDLE_BITS     20  consecutive idle-high bit periods after which record alignment resets
// PORTS
//  clk            in   1      receiver clock
//  reset_n        in   1      asynchronous active-low reset
//  UART_in        in   1      serial line, idle high, asynchronous to clk
//  waveform       out  14x32  received sample buffer, waveform[i] = sample with index i
//  sample         out  14     last accepted sample value
//  sampleIndex    out  5      index of last accepted sample
//  sampleValid    out  1      1-cycle pulse when sample/sampleIndex/waveform entry update
//  waveformDone   out  1      1-cycle pulse when index N_SAMPLES-1 is accepted in sequence
//  frameError     out  1      1-cycle pulse: stop bit 0, start glitch, or hi byte bits[7:6]!=0
//  seqError       out  1      1-cycle pulse: index byte != expected index
// BEHAVIOUR
//  Reset: all outputs 0; waveform entries 0; FSM IDLE; bytePhase=0; expected=0; sync flops=1.
//  UART_in passes through a 2-flop synchroniser; all decisions use the synchronised value.
//  Bit FSM:
//   IDLE  : on a synchronised 1->0 transition, go to START with counter=0.
//   START : at count CLKS_PER_BIT/2-1 (mid-bit), if line=0 go to DATA, else frameError pulse, IDLE.
//   DATA  : sample every CLKS_PER_BIT cycles (mid-bit), shift in LSB-first; after 8 bits go to STOP.
//   STOP  : at mid-bit, line=1 -> byte valid; line=0 -> frameError pulse. Both cases return to IDLE
//           at mid-stop, so a start bit immediately following is detected.
//  Record assembly (bytePhase 0/1/2, advanced only on valid bytes):
//   phase0: hi byte; bits[7:6]!=0 -> frameError, stay in phase0; else hold bits[5:0], go to phase1.
//   phase1: lo byte; hold, go to phase2.
//   phase2: index byte; phase->0. If index==expected: write waveform[index]={hi,lo},
//           sample/sampleIndex update, sampleValid pulses; expected+1; if index==N_SAMPLES-1,
//           waveformDone pulses in the same cycle and expected->0.
//           If index==0 != expected: treat as new waveform start (accept, expected=1), seqError pulses.
//           Any other mismatch or index>=N_SAMPLES: seqError pulses, record discarded, expected->0.
//  Any frameError discards the partial record (bytePhase->0); expected is unchanged.
//  Idle counter: the line held 1 in IDLE for IDLE_BITS*CLKS_PER_BIT cycles -> bytePhase->0,
//   expected->0 (resync between bursts); no error flag.
//  Latency: sampleValid is asserted on the clk edge after the stop-bit mid sample of the index byte
//   (about 2 sync + CLKS_PER_BIT/2 cycles after the stop bit starts on UART_in).
//  waveform is registered; entries hold until overwritten. No clear on waveformDone.
//  Error and valid pulses are mutually exclusive except the index==0 restart case
//   (sampleValid and seqError both pulse).
//  reset_n low mid-byte aborts immediately; after release the receiver waits for line idle-high
//   then a falling edge.
// TESTING
//  1 Send record 0x2A,0x5B,0x00 at CLKS_PER_BIT=16 -> sampleValid once, sample=0x2A5B, sampleIndex=0,
//    waveform[0]=0x2A5B.
//  2 Send 32 records, sample i = 0x3FFF-i*0x101, indices 0..31, back-to-back -> 32 sampleValid pulses,
//    waveformDone with index 31, waveform matches, no errors.
//  3 Corrupt the stop bit of the lo byte in record 3 -> frameError pulse, record dropped; next
//    record with index 3 is accepted.
//  4 Records with indices 0,1,5 -> seqError at 5, nothing written at 5; following index 0 accepted
//    and seqError not raised.
//  5 Send 0xC1 as hi byte -> frameError; a 1-bit-period low glitch of under CLKS_PER_BIT/2 cycles
//    -> frameError, no byte.
//  6 Assert reset_n mid-DATA, release, then send a clean record -> outputs 0 during reset,
//    record received correctly; idle gap of 20 bits after hi byte -> phase realigns.

Source files
------------

// File: rtl/uart_to_waveform_if.sv
// Sample-stream bundle between the serial waveform receiver and its consumer.
// master = receiver (takes the serial line, drives sample/waveform/status); slave = host side.
interface uart_to_waveform_if #(
  parameter int N_SAMPLES = 32,
  parameter int IDXW      = $clog2(N_SAMPLES)
);
  logic                          UART_in;
  logic [N_SAMPLES-1:0][13:0]    waveform;
  logic [13:0]                   sample;
  logic [IDXW-1:0]               sampleIndex;
  logic                          sampleValid;
  logic                          waveformDone;
  logic                          frameError;
  logic                          seqError;

  modport master (
    input  UART_in,
    output waveform, sample, sampleIndex, sampleValid, waveformDone, frameError, seqError
  );

  modport slave (
    output UART_in,
    input  waveform, sample, sampleIndex, sampleValid, waveformDone, frameError, seqError
  );
endinterface

// File: rtl/uart_to_waveform.sv
// 8N1 receiver reassembling {hi,lo,index} records into a 14-bit sample waveform buffer.
// Outputs register one clk after the stop-bit mid sample; no backpressure, the line is never stalled.
module uart_to_waveform #(
  parameter int CLKS_PER_BIT = 16,
  parameter int N_SAMPLES    = 32,
  parameter int IDLE_BITS    = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_to_waveform_if.master bus
);

  localparam int HALF     = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int IDXW     = $clog2(N_SAMPLES);
  localparam int IDLE_CYC = IDLE_BITS * CLKS_PER_BIT;
  localparam int ICW      = $clog2(IDLE_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic                       sync1_q, sync1_d, sync2_q, sync2_d;
  logic                       prev_q, prev_d;
  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [2:0]                 bit_q, bit_d;
  logic [7:0]                 shift_q, shift_d;
  logic [ICW-1:0]             idle_q, idle_d;
  logic [1:0]                 phase_q, phase_d;
  logic [5:0]                 hi_q, hi_d;
  logic [7:0]                 lo_q, lo_d;
  logic [IDXW-1:0]            exp_q, exp_d;
  logic [N_SAMPLES-1:0][13:0] wave_q, wave_d;
  logic [13:0]                sample_q, sample_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic                       sv_q, sv_d, done_q, done_d, ferr_q, ferr_d, serr_q, serr_d;

  logic       line;
  logic       byte_vld;
  logic [7:0] byte_dat;

  always_comb begin
    sync1_d  = bus.UART_in;
    sync2_d  = sync1_q;
    line     = sync2_q;
    prev_d   = line;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    idle_d   = '0;
    phase_d  = phase_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    exp_d    = exp_q;
    wave_d   = wave_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    sv_d     = 1'b0;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    serr_d   = 1'b0;
    byte_vld = 1'b0;
    byte_dat = shift_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // prev_q resets low, so after reset a falling edge needs the line seen high first
        if (prev_q && !line) state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          if (!line) begin
            state_d = S_DATA;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (line) byte_vld = 1'b1;
          else      ferr_d   = 1'b1;
        end
      end
    endcase

    if (byte_vld) begin
      case (phase_q)
        2'd0: begin
          if (byte_dat[7:6] != 2'b00) begin
            ferr_d = 1'b1;
          end else begin
            hi_d    = byte_dat[5:0];
            phase_d = 2'd1;
          end
        end
        2'd1: begin
          lo_d    = byte_dat;
          phase_d = 2'd2;
        end
        default: begin
          phase_d = 2'd0;
          if (byte_dat == 8'(exp_q) || byte_dat == 8'd0) begin
            wave_d[byte_dat[IDXW-1:0]] = {hi_q, lo_q};
            sample_d = {hi_q, lo_q};
            idx_d    = byte_dat[IDXW-1:0];
            sv_d     = 1'b1;
            if (byte_dat != 8'(exp_q)) begin
              // index 0 out of sequence: a new waveform has started
              serr_d = 1'b1;
              exp_d  = IDXW'(1);
            end else if (exp_q == IDXW'(N_SAMPLES - 1)) begin
              done_d = 1'b1;
              exp_d  = '0;
            end else begin
              exp_d = exp_q + 1'b1;
            end
          end else begin
            serr_d = 1'b1;
            exp_d  = '0;
          end
        end
      endcase
    end

    if (ferr_d) phase_d = 2'd0;

    // a long idle-high gap realigns the record framing between bursts
    if (state_q == S_IDLE && line) begin
      idle_d = idle_q;
      if (idle_q != ICW'(IDLE_CYC)) begin
        idle_d = idle_q + 1'b1;
        if (idle_q == ICW'(IDLE_CYC - 1)) begin
          phase_d = 2'd0;
          exp_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      idle_q   <= '0;
      phase_q  <= 2'd0;
      hi_q     <= '0;
      lo_q     <= '0;
      exp_q    <= '0;
      wave_q   <= '0;
      sample_q <= '0;
      idx_q    <= '0;
      sv_q     <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      idle_q   <= idle_d;
      phase_q  <= phase_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      exp_q    <= exp_d;
      wave_q   <= wave_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      sv_q     <= sv_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
      serr_q   <= serr_d;
    end
  end

  assign bus.waveform     = wave_q;
  assign bus.sample       = sample_q;
  assign bus.sampleIndex  = idx_q;
  assign bus.sampleValid  = sv_q;
  assign bus.waveformDone = done_q;
  assign bus.frameError   = ferr_q;
  assign bus.seqError     = serr_q;

endmodule

// File: tb/tb_uart_to_waveform.sv
// Bench for uart_to_waveform: directed record table, multi-cycle corner sequences,
// and a random record stream checked against a byte-stream reference model.
module tb_uart_to_waveform;

  localparam int CPB = 16;
  localparam int NS  = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_to_waveform_if #(.N_SAMPLES(NS)) bus ();

  uart_to_waveform #(.CLKS_PER_BIT(CPB), .N_SAMPLES(NS), .IDLE_BITS(20)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // pulse monitor, sampled on the falling edge
  int          mon_sv = 0, mon_done = 0, mon_frm = 0, mon_seq = 0;
  logic [13:0] last_sample = '0;
  logic [4:0]  last_idx = '0;
  logic [18:0] mon_q[$];

  always @(negedge clk) begin
    if (bus.sampleValid) begin
      mon_sv++;
      last_sample = bus.sample;
      last_idx    = bus.sampleIndex;
      mon_q.push_back({bus.sampleIndex, bus.sample});
    end
    if (bus.waveformDone) mon_done++;
    if (bus.frameError)   mon_frm++;
    if (bus.seqError)     mon_seq++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic send_bit(input logic v);
    bus.UART_in = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    if (!stop_ok) begin
      send_bit(1'b1);
      send_bit(1'b1);
    end
  endtask

  task automatic idle_bits(input int n);
    bus.UART_in = 1'b1;
    repeat (n * CPB) @(posedge clk);
  endtask

  // reference model: byte-level record framing from the protocol rules
  int          m_phase = 0, m_exp = 0, m_done = 0, m_frm = 0, m_seq = 0;
  logic [5:0]  m_hi;
  logic [7:0]  m_lo;
  logic [13:0] m_wave[NS];
  logic [18:0] m_q[$];

  task automatic model_byte(input logic [7:0] b);
    if (m_phase == 0) begin
      if (b >= 8'd64) m_frm++;
      else begin m_hi = b[5:0]; m_phase = 1; end
    end else if (m_phase == 1) begin
      m_lo = b; m_phase = 2;
    end else begin
      m_phase = 0;
      if (int'(b) == m_exp || b == 8'd0) begin
        m_wave[b[4:0]] = {m_hi, m_lo};
        m_q.push_back({b[4:0], m_hi, m_lo});
        if (int'(b) != m_exp) begin m_seq++; m_exp = 1; end
        else if (m_exp == NS - 1) begin m_done++; m_exp = 0; end
        else m_exp = m_exp + 1;
      end else begin
        m_seq++; m_exp = 0;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          nbytes;
    int          bad;
    int          sv, seq, frm, done;
    logic [13:0] smp;
    logic [4:0]  idx;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int s_sv, s_seq, s_frm, s_done, base;
    logic [7:0] rb[3];
    logic [13:0] v;

    tbl[0] = '{8'h2A, 8'h5B, 8'h00, 3, -1, 1, 0, 0, 0, 14'h2A5B, 5'd0};
    tbl[1] = '{8'h01, 8'h02, 8'h01, 3, -1, 1, 0, 0, 0, 14'h0102, 5'd1};
    tbl[2] = '{8'h03, 8'h04, 8'h05, 3, -1, 0, 1, 0, 0, 14'h0000, 5'd0};
    tbl[3] = '{8'h3F, 8'hFF, 8'h00, 3, -1, 1, 0, 0, 0, 14'h3FFF, 5'd0};
    tbl[4] = '{8'hC1, 8'h00, 8'h00, 1, -1, 0, 0, 1, 0, 14'h0000, 5'd0};
    tbl[5] = '{8'h00, 8'h11, 8'h01, 2,  1, 0, 0, 1, 0, 14'h0000, 5'd0};
    tbl[6] = '{8'h00, 8'h11, 8'h01, 3, -1, 1, 0, 0, 0, 14'h0011, 5'd1};
    tbl[7] = '{8'h05, 8'h06, 8'h00, 3, -1, 1, 1, 0, 0, 14'h0506, 5'd0};
    tbl[8] = '{8'h07, 8'h08, 8'h01, 3, -1, 1, 0, 0, 0, 14'h0708, 5'd1};

    reset_n     = 1'b0;
    bus.UART_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", 32'(bus.sample), 0);
    check("rst_index", 32'(bus.sampleIndex), 0);
    check("rst_pulses", {28'd0, bus.sampleValid, bus.waveformDone, bus.frameError, bus.seqError}, 0);
    check("rst_waveform_nonzero", 32'(bus.waveform != '0), 0);
    reset_n = 1'b1;
    idle_bits(2);

    // directed record table
    for (int r = 0; r < 9; r++) begin
      s_sv = mon_sv; s_seq = mon_seq; s_frm = mon_frm; s_done = mon_done;
      rb[0] = tbl[r].b0; rb[1] = tbl[r].b1; rb[2] = tbl[r].b2;
      for (int k = 0; k < tbl[r].nbytes; k++) send_byte(rb[k], k != tbl[r].bad);
      idle_bits(1);
      check($sformatf("row%0d_valid", r), mon_sv - s_sv, tbl[r].sv);
      check($sformatf("row%0d_seq", r), mon_seq - s_seq, tbl[r].seq);
      check($sformatf("row%0d_frame", r), mon_frm - s_frm, tbl[r].frm);
      check($sformatf("row%0d_done", r), mon_done - s_done, tbl[r].done);
      if (tbl[r].sv != 0) begin
        check($sformatf("row%0d_sample", r), 32'(last_sample), 32'(tbl[r].smp));
        check($sformatf("row%0d_index", r), 32'(last_idx), 32'(tbl[r].idx));
      end
    end
    check("wave0", 32'(bus.waveform[0]), 32'h0506);
    check("wave1", 32'(bus.waveform[1]), 32'h0708);
    check("wave5_untouched", 32'(bus.waveform[5]), 0);

    // start glitch shorter than half a bit
    s_sv = mon_sv; s_frm = mon_frm;
    bus.UART_in = 1'b0;
    repeat (CPB / 2 - 2) @(posedge clk);
    idle_bits(2);
    check("glitch_frame", mon_frm - s_frm, 1);
    check("glitch_no_byte", mon_sv - s_sv, 0);

    // reset in the middle of a data bit
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus.UART_in = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_sample", 32'(bus.sample), 0);
    check("midrst_waveform_nonzero", 32'(bus.waveform != '0), 0);
    repeat (4) @(posedge clk);
    bus.UART_in = 1'b1;
    repeat (4) @(posedge clk);
    reset_n = 1'b1;
    idle_bits(2);
    s_sv = mon_sv; s_seq = mon_seq; s_frm = mon_frm;
    send_byte(8'h0A, 1'b1); send_byte(8'h0B, 1'b1); send_byte(8'h00, 1'b1);
    idle_bits(1);
    check("postrst_valid", mon_sv - s_sv, 1);
    check("postrst_sample", 32'(last_sample), 32'h0A0B);
    check("postrst_errors", (mon_seq - s_seq) + (mon_frm - s_frm), 0);

    // lone hi byte then a long idle gap: framing must realign
    send_byte(8'h15, 1'b1);
    idle_bits(22);
    s_sv = mon_sv; s_seq = mon_seq;
    send_byte(8'h15, 1'b1); send_byte(8'h26, 1'b1); send_byte(8'h00, 1'b1);
    idle_bits(1);
    check("realign_valid", mon_sv - s_sv, 1);
    check("realign_seq", mon_seq - s_seq, 0);
    check("realign_sample", 32'(last_sample), 32'h1526);

    // full waveform, back to back
    idle_bits(22);
    s_sv = mon_sv; s_seq = mon_seq; s_frm = mon_frm; s_done = mon_done;
    for (int i = 0; i < NS; i++) begin
      v = 14'(16'h3FFF - i * 16'h0101);
      send_byte({2'b00, v[13:8]}, 1'b1);
      send_byte(v[7:0], 1'b1);
      send_byte(8'(i), 1'b1);
      m_wave[i] = v;
    end
    idle_bits(1);
    check("full_valid", mon_sv - s_sv, NS);
    check("full_done", mon_done - s_done, 1);
    check("full_errors", (mon_seq - s_seq) + (mon_frm - s_frm), 0);
    check("full_last_index", 32'(last_idx), NS - 1);
    for (int i = 0; i < NS; i++)
      check($sformatf("full_wave%0d", i), 32'(bus.waveform[i]), 32'(m_wave[i]));

    // random record stream against the reference model
    s_sv = mon_sv; s_seq = mon_seq; s_frm = mon_frm; s_done = mon_done;
    base = mon_q.size();
    m_phase = 0; m_exp = 0;
    for (int r = 0; r < 30; r++) begin
      int sel;
      rb[0] = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) rb[0] = rb[0] | 8'h80;
      rb[1] = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      if (sel < 7)       rb[2] = 8'(m_exp + (m_phase == 1 ? 0 : 0));
      else if (sel == 7) rb[2] = 8'h00;
      else               rb[2] = 8'($urandom_range(0, 40));
      for (int k = 0; k < 3; k++) begin
        send_byte(rb[k], 1'b1);
        model_byte(rb[k]);
      end
    end
    idle_bits(1);
    check("rnd_valid", mon_sv - s_sv, m_q.size());
    check("rnd_seq", mon_seq - s_seq, m_seq);
    check("rnd_frame", mon_frm - s_frm, m_frm);
    check("rnd_done", mon_done - s_done, m_done);
    for (int k = 0; k < m_q.size(); k++)
      check($sformatf("rnd_acc%0d", k),
            (base + k < mon_q.size()) ? 32'(mon_q[base + k]) : 32'hFFFF_FFFF, 32'(m_q[k]));
    for (int i = 0; i < NS; i++)
      check($sformatf("rnd_wave%0d", i), 32'(bus.waveform[i]), 32'(m_wave[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
